// File: rtl/router_pkg.sv
// Shared widths, FSM encoding and helpers for the router input arbiter.
package router_pkg;

    localparam int PORT_W = 2;
    localparam int DATA_W = 4;
    localparam int WORD_W = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 4-way round-robin picker: first set request after 'last', wrapping around.
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] w_cand;

    // Walk from lowest priority (last itself) to highest (last+1) so the best match wins.
    always_comb begin
        found  = 1'b0;
        idx    = 2'd0;
        w_cand = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_cand = last + 2'(k);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/router_arbiter.sv
// Four-requester round-robin front end for the secure Hamming router: grants one
// requester at a time with a bounded burst and keeps saturating per-destination counts.
module router_arbiter
    import router_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     req_dest,
    input  logic [4*N_REQ-1:0]     req_data,
    output logic [N_REQ-1:0]       gnt,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic [WORD_W-1:0]      router_d_in,
    output logic                   router_valid,
    output logic [4*CNT_W-1:0]     pkt_count
);

    localparam logic [3:0]       LP_MAX_BURST = 4'(MAX_BURST);
    localparam logic [CNT_W-1:0] LP_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LP_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_REQ-1:0]  r_gnt;
    logic [N_REQ-1:0]  w_gnt_nxt;
    logic [1:0]        r_owner;
    logic [1:0]        w_owner_nxt;
    logic [1:0]        r_last;
    logic [1:0]        w_last_nxt;
    logic [3:0]        r_burst;
    logic [3:0]        w_burst_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic [WORD_W-1:0] r_d_in;
    logic [WORD_W-1:0] w_d_in_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic [CNT_W-1:0]  r_cnt     [4];
    logic [CNT_W-1:0]  w_cnt_nxt [4];

    logic              w_found;
    logic [1:0]        w_pick;
    logic              w_owner_req;
    logic              w_xfer;
    logic              w_release;
    logic [3:0]        w_burst_inc;
    logic [PORT_W-1:0] w_dest;
    logic [DATA_W-1:0] w_data;

    rr_pick u_pick (
        .req   (req),
        .last  (r_last),
        .found (w_found),
        .idx   (w_pick)
    );

    // Owner's current word and the transfer/release decisions for this edge.
    always_comb begin
        w_dest      = req_dest[{r_owner, 1'b0} +: PORT_W];
        w_data      = req_data[{r_owner, 2'b00} +: DATA_W];
        w_owner_req = req[r_owner];
        w_burst_inc = r_burst + 4'd1;
        w_xfer      = (r_state == SERVE) && w_owner_req;
        // A dropped request wins over the burst limit: release without a transfer.
        w_release   = (r_state == SERVE) && (!w_owner_req || (w_burst_inc == LP_MAX_BURST));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = SERVE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SERVE: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = SERVE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, burst counter and priority pointer.
    always_comb begin
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_burst_nxt = r_burst;
        w_busy_nxt  = r_busy;
        w_valid_nxt = 1'b0;
        w_d_in_nxt  = {WORD_W{1'b0}};
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_gnt_nxt   = N_REQ'(onehot4(w_pick));
                    w_owner_nxt = w_pick;
                    w_burst_nxt = 4'd0;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b0;
                end
            end
            SERVE: begin
                if (w_xfer) begin
                    w_valid_nxt = 1'b1;
                    w_d_in_nxt  = {w_dest, w_data};
                    w_burst_nxt = w_burst_inc;
                end else begin
                    w_burst_nxt = r_burst;
                end
                if (w_release) begin
                    w_gnt_nxt  = {N_REQ{1'b0}};
                    w_busy_nxt = 1'b0;
                    w_last_nxt = r_owner;
                end else begin
                    w_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_gnt_nxt  = {N_REQ{1'b0}};
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Saturating per-destination transfer counters.
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            if (w_xfer && (w_dest == 2'(d)) && (r_cnt[d] != LP_CNT_MAX)) begin
                w_cnt_nxt[d] = r_cnt[d] + LP_CNT_ONE;
            end else begin
                w_cnt_nxt[d] = r_cnt[d];
            end
        end
    end

    // Output, pointer and counter registers; reset drops any word presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt   <= {N_REQ{1'b0}};
            r_owner <= 2'd0;
            r_last  <= 2'd3;
            r_burst <= 4'd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_d_in  <= {WORD_W{1'b0}};
            for (int d = 0; d < 4; d++) begin
                r_cnt[d] <= {CNT_W{1'b0}};
            end
        end else begin
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_burst <= w_burst_nxt;
            r_busy  <= w_busy_nxt;
            r_valid <= w_valid_nxt;
            r_d_in  <= w_d_in_nxt;
            for (int d = 0; d < 4; d++) begin
                r_cnt[d] <= w_cnt_nxt[d];
            end
        end
    end

    // Pack counters onto the flat debug port.
    always_comb begin
        pkt_count = {(4*CNT_W){1'b0}};
        for (int d = 0; d < 4; d++) begin
            pkt_count[d*CNT_W +: CNT_W] = r_cnt[d];
        end
    end

    assign gnt          = r_gnt;
    assign grant_id     = r_owner;
    assign busy         = r_busy;
    assign router_d_in  = r_d_in;
    assign router_valid = r_valid;

endmodule

// File: tb/tb_router_arbiter.sv
// Directed scoreboard bench for router_arbiter: default, single-word-burst and 2-bit-counter builds.
module tb_router_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  req_dest;
    logic [15:0] req_data;

    logic [3:0]  gnt_a, gnt_b, gnt_c;
    logic [1:0]  gid_a, gid_b, gid_c;
    logic        busy_a, busy_b, busy_c;
    logic [5:0]  din_a, din_b, din_c;
    logic        val_a, val_b, val_c;
    logic [31:0] cnt_a, cnt_b;
    logic [7:0]  cnt_c;

    logic [1:0]  sel;
    logic [3:0]  s_gnt;
    logic [1:0]  s_gid;
    logic        s_busy;
    logic [5:0]  s_din;
    logic        s_val;
    logic [31:0] s_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [5:0]  exp_q[$];
    int          exp_cnt[4];
    int          o;
    logic [3:0]  nib;
    int          owners[5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    router_arbiter #(.N_REQ(4), .MAX_BURST(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_dest(req_dest), .req_data(req_data),
        .gnt(gnt_a), .grant_id(gid_a), .busy(busy_a), .router_d_in(din_a),
        .router_valid(val_a), .pkt_count(cnt_a)
    );

    router_arbiter #(.N_REQ(4), .MAX_BURST(1), .CNT_W(8)) u_b1 (
        .clk(clk), .rst(rst), .req(req), .req_dest(req_dest), .req_data(req_data),
        .gnt(gnt_b), .grant_id(gid_b), .busy(busy_b), .router_d_in(din_b),
        .router_valid(val_b), .pkt_count(cnt_b)
    );

    router_arbiter #(.N_REQ(4), .MAX_BURST(4), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .req(req), .req_dest(req_dest), .req_data(req_data),
        .gnt(gnt_c), .grant_id(gid_c), .busy(busy_c), .router_d_in(din_c),
        .router_valid(val_c), .pkt_count(cnt_c)
    );

    always_comb begin
        case (sel)
            2'd1:    begin s_gnt = gnt_b; s_gid = gid_b; s_busy = busy_b; s_din = din_b; s_val = val_b; s_cnt = cnt_b; end
            2'd2:    begin s_gnt = gnt_c; s_gid = gid_c; s_busy = busy_c; s_din = din_c; s_val = val_c; s_cnt = {24'd0, cnt_c}; end
            default: begin s_gnt = gnt_a; s_gid = gid_a; s_busy = busy_a; s_din = din_a; s_val = val_a; s_cnt = cnt_a; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack8(input int c0, input int c1, input int c2, input int c3);
        return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    // Advance one edge, then pop the scoreboard for any word the selected DUT forwarded.
    task automatic tick();
        logic [5:0] w;
        @(posedge clk);
        #1;
        if (s_val === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(s_val), 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("word", 32'(s_din), 32'(w));
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        for (int d = 0; d < 4; d++) exp_cnt[d] = 0;
    endtask

    initial begin
        sel      = 2'd0;
        rst      = 1'b1;
        req      = 4'hF;
        req_dest = 8'd0;
        req_data = 16'd0;
        for (int d = 0; d < 4; d++) exp_cnt[d] = 0;

        // Reset held with every requester asking.
        tick(); tick(); tick();
        check("rst_gnt",   32'(s_gnt),  32'd0);
        check("rst_busy",  32'(s_busy), 32'd0);
        check("rst_valid", 32'(s_val),  32'd0);
        check("rst_din",   32'(s_din),  32'd0);
        check("rst_cnt",   s_cnt,       32'd0);
        rst = 1'b0;
        tick();
        check("rst_first_gnt",  32'(s_gnt),  32'h1);
        check("rst_first_gid",  32'(s_gid),  32'd0);
        check("rst_first_busy", 32'(s_busy), 32'd1);
        check("arb_no_xfer",    32'(s_val),  32'd0);

        // Single short request from requester 2.
        do_reset();
        req_dest = 8'b00_01_00_00;
        req_data = 16'h0A00;
        req      = 4'b0100;
        tick();
        check("short_gnt", 32'(s_gnt), 32'h4);
        check("short_gid", 32'(s_gid), 32'd2);
        exp_q.push_back(6'b01_1010);
        tick();
        exp_q.push_back(6'b01_1010);
        tick();
        check("short_hold", 32'(s_gnt), 32'h4);
        req = 4'b0000;
        tick();
        check("short_rel_gnt",   32'(s_gnt),  32'd0);
        check("short_rel_busy",  32'(s_busy), 32'd0);
        check("short_rel_valid", 32'(s_val),  32'd0);
        check("short_cnt",       s_cnt,       32'h0000_0200);
        check("short_q_empty",   32'(exp_q.size()), 32'd0);

        // All four requesting continuously, bursts of 4.
        do_reset();
        req_dest = 8'b01_00_10_11;
        req      = 4'hF;
        for (int b = 0; b < 5; b++) begin
            o = owners[b];
            tick();
            check("rr_gnt",      32'(s_gnt), 32'(4'b0001 << o));
            check("rr_arb_idle", 32'(s_val), 32'd0);
            for (int w = 0; w < 4; w++) begin
                nib = 4'(o * 4 + w + b);
                req_data[4*o +: 4] = nib;
                exp_q.push_back({req_dest[2*o +: 2], nib});
                exp_cnt[req_dest[2*o +: 2]]++;
                tick();
                if (w < 3) begin
                    check("rr_hold", 32'(s_gnt), 32'(4'b0001 << o));
                end else begin
                    check("rr_release", 32'(s_gnt),  32'd0);
                    check("rr_busy",    32'(s_busy), 32'd0);
                end
            end
        end
        req = 4'b0000;
        check("rr_cnt", s_cnt, pack8(exp_cnt[0], exp_cnt[1], exp_cnt[2], exp_cnt[3]));
        check("rr_q_empty", 32'(exp_q.size()), 32'd0);

        // Fairness with single-word bursts.
        sel = 2'd1;
        do_reset();
        req_dest = 8'b10_00_00_01;
        req      = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            o = (k % 2 == 0) ? 0 : 3;
            tick();
            check("fair_gnt",   32'(s_gnt), 32'(4'b0001 << o));
            check("fair_idle",  32'(s_val), 32'd0);
            nib = 4'(k + 5);
            req_data[4*o +: 4] = nib;
            exp_q.push_back({req_dest[2*o +: 2], nib});
            tick();
            check("fair_valid", 32'(s_val), 32'd1);
            check("fair_rel",   32'(s_gnt), 32'd0);
        end
        req = 4'b0000;
        check("fair_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset on the third transfer edge of requester 1.
        sel = 2'd0;
        do_reset();
        req_dest = 8'b0000_1000;
        req      = 4'b0010;
        tick();
        check("mid_gnt", 32'(s_gnt), 32'h2);
        req_data[7:4] = 4'h3;
        exp_q.push_back(6'b10_0011);
        tick();
        req_data[7:4] = 4'h4;
        exp_q.push_back(6'b10_0100);
        tick();
        check("mid_cnt_before", s_cnt, 32'h0002_0000);
        req_data[7:4] = 4'h5;
        rst = 1'b1;
        tick();
        check("mid_gnt_rst",   32'(s_gnt), 32'd0);
        check("mid_valid_rst", 32'(s_val), 32'd0);
        check("mid_cnt_rst",   s_cnt,      32'd0);
        rst = 1'b0;
        tick();
        check("mid_regrant", 32'(s_gnt), 32'h2);
        req = 4'b0000;
        check("mid_q_empty", 32'(exp_q.size()), 32'd0);

        // Saturation of 2-bit counters.
        sel = 2'd2;
        do_reset();
        req_dest = 8'b0000_0011;
        req      = 4'b0001;
        tick();
        check("sat_gnt", 32'(s_gnt), 32'h1);
        for (int w = 0; w < 4; w++) begin
            nib = 4'(w + 9);
            req_data[3:0] = nib;
            exp_q.push_back({2'b11, nib});
            tick();
        end
        check("sat_burst_rel", 32'(s_gnt), 32'd0);
        tick();
        check("sat_regrant", 32'(s_gnt), 32'h1);
        req_data[3:0] = 4'hE;
        exp_q.push_back(6'b11_1110);
        tick();
        check("sat_cnt3", s_cnt, 32'h0000_00C0);
        req = 4'b0010;
        tick();
        check("sat_drop_rel",   32'(s_gnt), 32'd0);
        check("sat_drop_valid", 32'(s_val), 32'd0);
        tick();
        check("sat_gnt1", 32'(s_gnt), 32'h2);
        req_data[7:4] = 4'h6;
        exp_q.push_back(6'b00_0110);
        tick();
        req = 4'b0000;
        tick();
        check("sat_cnt_final", s_cnt, 32'h0000_00C1);
        check("sat_q_empty",   32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_arbiter.md
Name: router_arbiter

Overview:
- Shares the single 6-bit input of the secure Hamming router among four requesters.
- Each requester offers a 2-bit destination port and a 4-bit payload.
- A round-robin arbiter with a bounded burst length grants one requester at a time and forwards its words as {dest, data} on the router input.
- Keeps saturating per-destination packet counters for debug and statistics.

Parameters:
- N_REQ, 4, number of requesters; the logic is written for 4 and other values are not supported.
- MAX_BURST, 4, maximum words accepted per grant before forced release; legal range 1..15.
- CNT_W, 8, width of each per-destination packet counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-requester request; the requester holds it high while it has words to send.
- req_dest  input  8  2-bit destination per requester; requester i uses bits [2i+1:2i].
- req_data  input  16  4-bit payload per requester; requester i uses bits [4i+3:4i].
- gnt  output  4  one-hot grant, registered.
- grant_id  output  2  index of the current or most recent owner.
- busy  output  1  high while in SERVE.
- router_d_in  output  6  {dest[1:0], data[3:0]}; drives the router's d_in.
- router_valid  output  1  high for the cycle in which router_d_in carries a transferred word.
- pkt_count  output  4*CNT_W  saturating transfer count per destination; destination d uses bits [CNT_W*(d+1)-1 : CNT_W*d].

Behaviour:
- Reset (synchronous, active-high):
  - Clears state to IDLE.
  - gnt, busy, router_d_in, router_valid, grant_id, burst counter and all pkt_count are 0.
  - last_winner=3, so requester 0 has top priority after reset.
  - Reset asserted mid-burst aborts the burst immediately. Any word presented that edge is dropped and not counted.
- FSM states: IDLE, SERVE.
- IDLE:
  - At an edge with req!=0, select the first requester with req set, searching last_winner+1, +2, +3, +4 (mod 4).
  - Set owner, gnt=onehot(owner), grant_id=owner, busy=1, burst_cnt=0, then go to SERVE.
  - No transfer happens on the arbitration edge.
  - With req==0, stay in IDLE.
- SERVE, evaluated each edge:
  - If req[owner]=1, transfer:
    - router_d_in <= {req_dest[owner], req_data[owner]} and router_valid <= 1.
    - pkt_count[dest] increments, saturating at 2^CNT_W-1.
    - burst_cnt increments.
    - If burst_cnt+1==MAX_BURST, release on this same edge.
  - If req[owner]=0, release with no transfer.
  - Release means: gnt=0, busy=0, last_winner=owner, go to IDLE.
- Latency and gaps:
  - A grant is visible 1 cycle after the request is sampled.
  - First data appears 2 cycles after the request.
  - There is always exactly one IDLE cycle between grants.
  - Maximum throughput is MAX_BURST words per MAX_BURST+1 cycles.
- router_valid and router_d_in:
  - When no transfer occurred at the previous edge, router_valid=0 and router_d_in=0.
  - This zeroing matches the router's zero-default output behaviour.
- Requester contract:
  - Data is consumed at every edge where gnt[i]=1 and req[i]=1.
  - The requester must advance to its next word after each such edge.
  - Changes to the requests of non-owners during SERVE have no effect.
- Simultaneous events:
  - The owner dropping req on the same edge the burst limit would be hit is treated as a plain release with no transfer.
  - Saturation of one counter does not affect the other counters.
- gnt is always one-hot or zero, and never changes except at arbitration and release edges.

Decomposition:
- Shared package router_pkg:
  - PORT_W=2, DATA_W=4, WORD_W=6.
  - FSM state constants IDLE=1'b0, SERVE=1'b1.
- Sub-module rr_pick: combinational 4-way round-robin priority picker.
  - Inputs: req[3:0], last[1:0].
  - Outputs: found, idx[1:0].
- The FSM, burst counter, output registers and counters live in router_arbiter.

Test Plan:
- Reset: hold rst for 3 cycles with all req=1 -> gnt=0, busy=0, router_valid=0, router_d_in=0, all pkt_count=0. After release, requester 0 is granted first.
- Single short request: req[2]=1, dest=2'b01, data=4'hA, held for 2 transfers then dropped -> gnt=4'b0100 one cycle after the request. router_valid is high for 2 cycles with router_d_in=6'b011010, then the grant drops. pkt_count for destination 1 = 2; others 0.
- All four requesting continuously with MAX_BURST=4 -> grant order 0,1,2,3,0. Each owner gets exactly 4 valid words, with one idle cycle between owners. Each destination count reflects its req_dest.
- Fairness with MAX_BURST=1, req[0] and req[3] held high -> grants alternate 0,3,0,3. Each grant carries 1 word; router_valid follows the pattern 1,0,1,0... with the first word arriving 2 cycles after the request.
- Reset mid-burst: assert rst on the 3rd transfer edge of requester 1 -> only 2 words are counted, and the next cycle shows gnt=0 and router_valid=0. After release with req[1] still high, requester 1 is re-granted.
- Saturation with CNT_W=2: 5 transfers to destination 3 -> pkt_count for destination 3 stops at 3, while a transfer to destination 0 still increments destination 0's count to 1.
